ras_stack_ckpt: RTL

RAS_STACK_CKPT -- requirements
Module: ras_stack_ckpt

---
 rtl/ras_stack_ckpt.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ras_stack_ckpt.sv
// ras_stack_ckpt: circular return-address stack with one checkpoint slot
// for mispredict recovery.
//
// Parameters:
//   XLEN       return-address width
//   RAS_DEPTH  number of entries (2..64, any integer)
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   flush_i      empty the stack (entries kept, pointer/count cleared)
//   push_i       push addr_i (call)
//   pop_i        pop top-of-stack (return)
//   addr_i       return address to push
//   snap_i       capture checkpoint (pointer and count)
//   restore_i    restore checkpoint
//   top_valid_o  stack non-empty (combinational from registered state)
//   top_addr_o   current top-of-stack entry (combinational from registered state)
//   count_o      occupied entries
//   overflow_o   registered one-cycle pulse: oldest entry overwritten
//   underflow_o  registered one-cycle pulse: pop on empty
//
// Optional feature macro RAS_STACK_STATS_EN adds:
//   ovf_cnt_o    saturating count of overflow pulses
//   udf_cnt_o    saturating count of underflow pulses
module ras_stack_ckpt #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  logic                             push_i,
    input  logic                             pop_i,
    input  logic [XLEN-1:0]                  addr_i,
    input  logic                             snap_i,
    input  logic                             restore_i,
    output logic                             top_valid_o,
    output logic [XLEN-1:0]                  top_addr_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   count_o,
    output logic                             overflow_o,
    output logic                             underflow_o
`ifdef RAS_STACK_STATS_EN
   ,output logic [15:0]                      ovf_cnt_o,
    output logic [15:0]                      udf_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    typedef struct packed {
        logic [PTR_W-1:0] ptr;
        logic [CNT_W-1:0] cnt;
    } ckpt_t;

    logic [XLEN-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] tos_ptr_q;
    logic [CNT_W-1:0] count_q;
    ckpt_t            ckpt_q;

    logic [PTR_W-1:0] tos_ptr_n;
    logic [CNT_W-1:0] count_n;
    ckpt_t            ckpt_n;
    logic             ovf_n;
    logic             udf_n;
    logic             we;
    logic [PTR_W-1:0] waddr;

    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic             empty;
    logic             full;

    // Modulo-RAS_DEPTH pointer neighbours (depth need not be a power of two)
    always_comb begin
        ptr_inc = (tos_ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : tos_ptr_q + PTR_W'(1);
        ptr_dec = (tos_ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : tos_ptr_q - PTR_W'(1);
        empty   = (count_q == '0);
        full    = (count_q == CNT_W'(RAS_DEPTH));
    end

    // Next-state: flush > restore > push/pop; reset handled in the register
    always_comb begin
        tos_ptr_n = tos_ptr_q;
        count_n   = count_q;
        ckpt_n    = ckpt_q;
        ovf_n     = 1'b0;
        udf_n     = 1'b0;
        we        = 1'b0;
        waddr     = tos_ptr_q;

        if (flush_i) begin
            tos_ptr_n = '0;
            count_n   = '0;
        end else if (restore_i) begin
            tos_ptr_n = ckpt_q.ptr;
            count_n   = ckpt_q.cnt;
        end else begin
            // Checkpoint holds the pre-update state of this cycle
            if (snap_i) begin
                ckpt_n.ptr = tos_ptr_q;
                ckpt_n.cnt = count_q;
            end

            if (push_i && pop_i && !empty) begin
                // Call replacing a return: rewrite top in place
                we    = 1'b1;
                waddr = tos_ptr_q;
            end else if (push_i) begin
                // Push-only, or push+pop on empty (behaves as push, flags underflow)
                udf_n     = pop_i;
                tos_ptr_n = ptr_inc;
                we        = 1'b1;
                waddr     = ptr_inc;
                if (full) begin
                    ovf_n = 1'b1;
                end else begin
                    count_n = count_q + CNT_W'(1);
                end
            end else if (pop_i) begin
                if (empty) begin
                    udf_n = 1'b1;
                end else begin
                    tos_ptr_n = ptr_dec;
                    count_n   = count_q - CNT_W'(1);
                end
            end
        end
    end

    // State, entry array and pulse registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tos_ptr_q   <= '0;
            count_q     <= '0;
            ckpt_q      <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tos_ptr_q   <= tos_ptr_n;
            count_q     <= count_n;
            ckpt_q      <= ckpt_n;
            overflow_o  <= ovf_n;
            underflow_o <= udf_n;
            if (we) begin
                mem_q[waddr] <= addr_i;
            end
        end
    end

`ifdef RAS_STACK_STATS_EN
    // Saturating event counters; survive flush, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_cnt_o <= '0;
            udf_cnt_o <= '0;
        end else begin
            if (ovf_n && (ovf_cnt_o != 16'hFFFF)) begin
                ovf_cnt_o <= ovf_cnt_o + 16'd1;
            end
            if (udf_n && (udf_cnt_o != 16'hFFFF)) begin
                udf_cnt_o <= udf_cnt_o + 16'd1;
            end
        end
    end
`endif

    // Zero-latency top-of-stack view
    assign top_valid_o = !empty;
    assign top_addr_o  = mem_q[tos_ptr_q];
    assign count_o     = count_q;

endmodule
